// File: rtl/hamming_rx_deframer_if.sv
// Channel-side serial input and decoder-side codeword handshake for hamming_rx_deframer.
// The slave modport is the deframer's view; the master modport is the channel/consumer side.
interface hamming_rx_deframer_if #(
    parameter int CODE_W = 7,
    parameter int CNT_W  = 8
);
    logic              bit_in;
    logic              bit_valid;
    logic [CODE_W-1:0] code_out;
    logic              code_valid;
    logic              code_ready;
    logic              frame_err;
    logic              overrun;
    logic [CNT_W-1:0]  frame_cnt;

    modport slave (
        input  bit_in, bit_valid, code_ready,
        output code_out, code_valid, frame_err, overrun, frame_cnt
    );

    modport master (
        output bit_in, bit_valid, code_ready,
        input  code_out, code_valid, frame_err, overrun, frame_cnt
    );
endinterface

// File: rtl/hamming_rx_deframer.sv
// Serial deframer feeding the Hamming decoder: start bit, CODE_W data bits MSB first, stop bit.
// Each good codeword goes into a one-deep valid/ready holding register; errors come out as one-cycle pulses.
module hamming_rx_deframer #(
    parameter int CODE_W = 7,
    parameter int CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    hamming_rx_deframer_if.slave  bus
);
    localparam int BIT_W = (CODE_W > 1) ? $clog2(CODE_W) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(CODE_W - 1);

    typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;

    state_t            r_state, w_state_nxt;
    logic [BIT_W-1:0]  r_bit, w_bit_nxt;
    logic [CODE_W-1:0] r_shift, w_shift_nxt;
    logic [CODE_W-1:0] r_code_out;
    logic              r_code_valid;
    logic              r_frame_err;
    logic              r_overrun;
    logic [CNT_W-1:0]  r_frame_cnt;

    logic w_stop_good, w_stop_bad, w_load, w_drop, w_accept;

    // NOTE: every always_comb output is given a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_stop_good = 1'b0;
        w_stop_bad  = 1'b0;
        if (bus.bit_valid) begin
            case (r_state)
                IDLE: begin
                    if (!bus.bit_in) begin
                        w_state_nxt = DATA;
                        w_bit_nxt   = '0;
                    end
                end
                DATA: begin
                    w_shift_nxt = {r_shift[CODE_W-2:0], bus.bit_in};
                    w_bit_nxt   = r_bit + 1'b1;
                    if (r_bit == LAST_BIT) w_state_nxt = STOP;
                end
                STOP: begin
                    // A 0 stop bit ends the frame too; it is never taken as the next start bit.
                    w_state_nxt = IDLE;
                    w_stop_good = bus.bit_in;
                    w_stop_bad  = !bus.bit_in;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    assign w_accept = r_code_valid && bus.code_ready;
    assign w_load   = w_stop_good && (!r_code_valid || bus.code_ready);
    assign w_drop   = w_stop_good && r_code_valid && !bus.code_ready;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_code_out   <= '0;
            r_code_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
            r_frame_cnt  <= '0;
        end else begin
            r_frame_err <= w_stop_bad;
            r_overrun   <= w_drop;
            if (w_load) begin
                r_code_out   <= w_shift_nxt;
                r_code_valid <= 1'b1;
                r_frame_cnt  <= r_frame_cnt + 1'b1;
            end else if (w_accept) begin
                r_code_valid <= 1'b0;
            end
        end
    end

    assign bus.code_out   = r_code_out;
    assign bus.code_valid = r_code_valid;
    assign bus.frame_err  = r_frame_err;
    assign bus.overrun    = r_overrun;
    assign bus.frame_cnt  = r_frame_cnt;
endmodule

// File: tb/tb_hamming_rx_deframer.sv
// Scoreboard bench for hamming_rx_deframer: expected codewords are queued when a frame is sent
// and compared when the consumer accepts them; pulses and counters are checked directly.
module tb_hamming_rx_deframer;
    localparam int CODE_W = 7;
    localparam int CNT_W  = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hamming_rx_deframer_if #(.CODE_W(CODE_W), .CNT_W(CNT_W)) ifc ();

    hamming_rx_deframer #(.CODE_W(CODE_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    int n_total = 0;
    int n_bad   = 0;

    logic [CODE_W-1:0] sb_q[$];
    logic [CNT_W-1:0]  exp_cnt = '0;
    int err_cycles = 0, ovr_cycles = 0, both_cycles = 0;
    int exp_err = 0, exp_ovr = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Consumer side: an accept happens on the next edge when valid && ready are seen here.
    always @(negedge clk) begin
        if (!reset) begin
            if (ifc.frame_err) err_cycles++;
            if (ifc.overrun) ovr_cycles++;
            if (ifc.frame_err && ifc.overrun) both_cycles++;
            if (ifc.code_valid && ifc.code_ready) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_word", 32'(ifc.code_out), 32'hFFFF_FFFF);
                end else begin
                    check("sb_code_out", 32'(ifc.code_out), 32'(sb_q.pop_front()));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Idle cycles drive random bit_in with bit_valid low; the DUT must ignore them.
    task automatic send_bit(input logic b, input int gap);
        repeat (gap) begin
            ifc.bit_valid = 1'b0;
            ifc.bit_in    = 1'($urandom);
            tick();
        end
        ifc.bit_in    = b;
        ifc.bit_valid = 1'b1;
        tick();
        ifc.bit_valid = 1'b0;
        ifc.bit_in    = 1'b1;
    endtask

    task automatic send_frame(input logic [CODE_W-1:0] code, input logic stop, input int gap,
                              input bit exp_load, input bit rdy_at_stop);
        send_bit(1'b0, gap);
        for (int i = CODE_W - 1; i >= 0; i--) send_bit(code[i], gap);
        if (exp_load) begin
            sb_q.push_back(code);
            exp_cnt = exp_cnt + 1'b1;
        end
        if (rdy_at_stop) ifc.code_ready = 1'b1;
        send_bit(stop, gap);
    endtask

    task automatic accept_one();
        ifc.code_ready = 1'b1;
        tick();
        ifc.code_ready = 1'b0;
    endtask

    initial begin
        logic [CODE_W-1:0] w1, w2;
        ifc.bit_in     = 1'b1;
        ifc.bit_valid  = 1'b0;
        ifc.code_ready = 1'b0;
        reset          = 1'b1;
        repeat (2) tick();
        check("rst_code_valid", 32'(ifc.code_valid), 32'd0);
        check("rst_code_out", 32'(ifc.code_out), 32'd0);
        check("rst_frame_cnt", 32'(ifc.frame_cnt), 32'd0);
        check("rst_pulses", {30'd0, ifc.frame_err, ifc.overrun}, 32'd0);
        reset = 1'b0;
        tick();

        // Back-to-back bits; codeword visible right after the stop-bit edge.
        send_frame(7'b0101011, 1'b1, 0, 1'b1, 1'b0);
        check("f1_valid", 32'(ifc.code_valid), 32'd1);
        check("f1_code", 32'(ifc.code_out), 32'h2B);
        check("f1_cnt", 32'(ifc.frame_cnt), 32'd1);
        accept_one();
        check("f1_cleared", 32'(ifc.code_valid), 32'd0);

        // Gapped bits with random bit_in on idle cycles.
        send_frame(7'b1001101, 1'b1, 1, 1'b1, 1'b0);
        check("f2_code", 32'(ifc.code_out), 32'h4D);
        check("f2_cnt", 32'(ifc.frame_cnt), 32'(exp_cnt));
        accept_one();

        // Bad stop bit: one-cycle frame_err, nothing loaded.
        send_frame(7'b0000001, 1'b0, 0, 1'b0, 1'b0);
        exp_err++;
        check("ferr_pulse", 32'(ifc.frame_err), 32'd1);
        check("ferr_no_valid", 32'(ifc.code_valid), 32'd0);
        tick();
        check("ferr_one_cycle", 32'(ifc.frame_err), 32'd0);
        check("ferr_cnt_same", 32'(ifc.frame_cnt), 32'(exp_cnt));
        send_frame(7'b0000001, 1'b1, 0, 1'b1, 1'b0);
        check("after_err_code", 32'(ifc.code_out), 32'h01);
        accept_one();

        // Two frames with no consumer: second is dropped, overrun pulses once.
        w1 = 7'($urandom);
        w2 = ~w1;
        send_frame(w1, 1'b1, 0, 1'b1, 1'b0);
        send_frame(w2, 1'b1, 0, 1'b0, 1'b0);
        exp_ovr++;
        check("ovr_pulse", 32'(ifc.overrun), 32'd1);
        check("ovr_hold_code", 32'(ifc.code_out), 32'(w1));
        check("ovr_cnt", 32'(ifc.frame_cnt), 32'(exp_cnt));
        tick();
        check("ovr_one_cycle", 32'(ifc.overrun), 32'd0);
        accept_one();
        check("ovr_drained", 32'(ifc.code_valid), 32'd0);

        // Accept and load on the same edge.
        w1 = 7'h55;
        w2 = 7'h1E;
        send_frame(w1, 1'b1, 0, 1'b1, 1'b0);
        send_frame(w2, 1'b1, 0, 1'b1, 1'b1);
        ifc.code_ready = 1'b0;
        check("b2b_valid", 32'(ifc.code_valid), 32'd1);
        check("b2b_code", 32'(ifc.code_out), 32'(w2));
        check("b2b_no_ovr", 32'(ifc.overrun), 32'd0);
        check("b2b_cnt", 32'(ifc.frame_cnt), 32'(exp_cnt));
        accept_one();

        // Reset in the middle of a frame.
        send_bit(1'b0, 0);
        for (int i = 0; i < 4; i++) send_bit(1'(i), 0);
        reset = 1'b1;
        #1;
        check("midrst_valid", 32'(ifc.code_valid), 32'd0);
        check("midrst_cnt", 32'(ifc.frame_cnt), 32'd0);
        tick();
        reset   = 1'b0;
        exp_cnt = '0;
        tick();
        check("midrst_no_err", 32'(ifc.frame_err), 32'd0);
        send_frame(7'b0101011, 1'b1, 0, 1'b1, 1'b0);
        check("postrst_code", 32'(ifc.code_out), 32'h2B);
        check("postrst_cnt", 32'(ifc.frame_cnt), 32'd1);
        accept_one();

        // Counter wrap: 255 more frames with the consumer always ready.
        ifc.code_ready = 1'b1;
        for (int f = 0; f < 254; f++) send_frame(7'($urandom), 1'b1, 0, 1'b1, 1'b0);
        tick();
        check("wrap_cnt_255", 32'(ifc.frame_cnt), 32'd255);
        send_frame(7'($urandom), 1'b1, 0, 1'b1, 1'b0);
        tick();
        check("wrap_cnt_0", 32'(ifc.frame_cnt), 32'(exp_cnt));
        check("wrap_cnt_is0", 32'(ifc.frame_cnt), 32'd0);
        ifc.code_ready = 1'b0;
        repeat (2) tick();

        check("sb_leftover", 32'(sb_q.size()), 32'd0);
        check("err_cycles", 32'(err_cycles), 32'(exp_err));
        check("ovr_cycles", 32'(ovr_cycles), 32'(exp_ovr));
        check("err_ovr_together", 32'(both_cycles), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
